// File: rtl/npu_spm_defines.sv
// Shared scratchpad-memory definitions: lane count, piggyback width,
// per-lane data type and the result-collector state encoding.
`ifndef SM_PROCESSING_ELEMENTS
`define SM_PROCESSING_ELEMENTS 16
`endif
`ifndef SM_PIGGYBACK_DATA_LEN
`define SM_PIGGYBACK_DATA_LEN 8
`endif

package npu_spm_defines;
  localparam int unsigned SM_DATA_WIDTH = 32;

  typedef logic [SM_DATA_WIDTH-1:0] sm_data_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } collector_state_t;
endpackage

// File: rtl/scratchpad_memory_lane_merger.sv
// Per-lane select: satisfied lanes take the bank read data, others keep
// the accumulator value. Purely combinational.
module scratchpad_memory_lane_merger
  import npu_spm_defines::*;
#(
  parameter int unsigned NUM_LANES = `SM_PROCESSING_ELEMENTS
) (
  input  sm_data_t [NUM_LANES-1:0] acc_data,
  input  sm_data_t [NUM_LANES-1:0] read_data,
  input  logic     [NUM_LANES-1:0] satisfied_mask,
  output sm_data_t [NUM_LANES-1:0] merged_data
);

  // Lane-wise mux between accumulated and freshly read data
  always_comb begin
    merged_data = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      merged_data[i] = satisfied_mask[i] ? read_data[i] : acc_data[i];
    end
  end

endmodule

// File: rtl/scratchpad_memory_result_collector.sv
// Scratchpad result collector: merges multi-beat bank-stage results into
// one per-instruction output and pulses sm3_valid for one cycle.
// Optional lane-overlap detection: define SM_COLLECTOR_ERROR_CHECK_EN.
module scratchpad_memory_result_collector
  import npu_spm_defines::*;
#(
  parameter int unsigned NUM_LANES = `SM_PROCESSING_ELEMENTS,
  parameter int unsigned PB_LEN    = `SM_PIGGYBACK_DATA_LEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sm2_valid,
  input  logic                     sm2_is_store,
  input  logic     [NUM_LANES-1:0] sm2_satisfied_mask,
  input  sm_data_t [NUM_LANES-1:0] sm2_read_data,
  input  logic                     sm2_is_last_request,
  input  logic     [PB_LEN-1:0]    sm2_piggyback_data,
  output logic                     sm3_valid,
  output logic                     sm3_is_store,
  output sm_data_t [NUM_LANES-1:0] sm3_read_data,
  output logic     [PB_LEN-1:0]    sm3_piggyback_data,
  output logic                     sm3_error
);

  collector_state_t         state_q, state_d;
  sm_data_t [NUM_LANES-1:0] acc_data_q, acc_data_d;
  logic     [NUM_LANES-1:0] acc_mask_q, acc_mask_d;
  logic                     is_store_q, is_store_d;
  logic     [PB_LEN-1:0]    pb_q, pb_d;

  logic                     sm3_valid_q, sm3_valid_d;
  logic                     sm3_is_store_q, sm3_is_store_d;
  sm_data_t [NUM_LANES-1:0] sm3_read_data_q, sm3_read_data_d;
  logic     [PB_LEN-1:0]    sm3_pb_q, sm3_pb_d;

  logic                     first_beat;
  sm_data_t [NUM_LANES-1:0] base_data;
  logic     [NUM_LANES-1:0] base_mask;
  sm_data_t [NUM_LANES-1:0] merged_data;
  logic                     eff_store;
  logic     [PB_LEN-1:0]    eff_pb;

  // A first beat starts from an empty accumulator, so the last-beat merge
  // and the single-beat case share one datapath.
  assign first_beat = sm2_valid && (state_q == IDLE);
  assign base_data  = first_beat ? '0 : acc_data_q;
  assign base_mask  = first_beat ? '0 : acc_mask_q;
  assign eff_store  = first_beat ? sm2_is_store : is_store_q;
  assign eff_pb     = first_beat ? sm2_piggyback_data : pb_q;

  scratchpad_memory_lane_merger #(
    .NUM_LANES(NUM_LANES)
  ) u_lane_merger (
    .acc_data      (base_data),
    .read_data     (sm2_read_data),
    .satisfied_mask(sm2_satisfied_mask),
    .merged_data   (merged_data)
  );

  // Next-state, accumulator update and emit of the registered result
  always_comb begin
    state_d         = state_q;
    acc_data_d      = acc_data_q;
    acc_mask_d      = acc_mask_q;
    is_store_d      = is_store_q;
    pb_d            = pb_q;
    sm3_valid_d     = 1'b0;
    sm3_is_store_d  = sm3_is_store_q;
    sm3_read_data_d = sm3_read_data_q;
    sm3_pb_d        = sm3_pb_q;
    if (sm2_valid) begin
      acc_data_d = merged_data;
      acc_mask_d = base_mask | sm2_satisfied_mask;
      if (first_beat) begin
        is_store_d = sm2_is_store;
        pb_d       = sm2_piggyback_data;
      end
      if (sm2_is_last_request) begin
        state_d         = IDLE;
        sm3_valid_d     = 1'b1;
        sm3_is_store_d  = eff_store;
        sm3_read_data_d = eff_store ? '0 : merged_data;
        sm3_pb_d        = eff_pb;
      end else begin
        state_d = COLLECT;
      end
    end
  end

  // State, accumulator and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      acc_data_q      <= '0;
      acc_mask_q      <= '0;
      is_store_q      <= 1'b0;
      pb_q            <= '0;
      sm3_valid_q     <= 1'b0;
      sm3_is_store_q  <= 1'b0;
      sm3_read_data_q <= '0;
      sm3_pb_q        <= '0;
    end else begin
      state_q         <= state_d;
      acc_data_q      <= acc_data_d;
      acc_mask_q      <= acc_mask_d;
      is_store_q      <= is_store_d;
      pb_q            <= pb_d;
      sm3_valid_q     <= sm3_valid_d;
      sm3_is_store_q  <= sm3_is_store_d;
      sm3_read_data_q <= sm3_read_data_d;
      sm3_pb_q        <= sm3_pb_d;
    end
  end

  assign sm3_valid          = sm3_valid_q;
  assign sm3_is_store       = sm3_is_store_q;
  assign sm3_read_data      = sm3_read_data_q;
  assign sm3_piggyback_data = sm3_pb_q;

`ifdef SM_COLLECTOR_ERROR_CHECK_EN
  logic err_q, err_d;
  logic sm3_error_q, sm3_error_d;
  logic overlap;

  // base_mask is zero on a first beat, so the sticky flag restarts there
  assign overlap = |(sm2_satisfied_mask & base_mask);

  // Sticky overlap flag, reported alongside the emit
  always_comb begin
    err_d       = err_q;
    sm3_error_d = sm3_error_q;
    if (sm2_valid) begin
      err_d = (first_beat ? 1'b0 : err_q) | overlap;
      if (sm2_is_last_request) begin
        sm3_error_d = err_d;
      end
    end
  end

  // Overlap flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      sm3_error_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      sm3_error_q <= sm3_error_d;
    end
  end

  assign sm3_error = sm3_error_q;
`else
  assign sm3_error = 1'b0;
`endif

endmodule

// File: tb/tb_scratchpad_memory_result_collector.sv
// Randomized bench for scratchpad_memory_result_collector with an
// instruction-level reference model.
module tb_scratchpad_memory_result_collector;
  import npu_spm_defines::*;

  localparam int NL  = 16;
  localparam int PBL = 8;
  localparam int VW  = NL * 32;
`ifdef SM_COLLECTOR_ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              sm2_valid;
  logic              sm2_is_store;
  logic [NL-1:0]     sm2_satisfied_mask;
  sm_data_t [NL-1:0] sm2_read_data;
  logic              sm2_is_last_request;
  logic [PBL-1:0]    sm2_piggyback_data;
  logic              sm3_valid;
  logic              sm3_is_store;
  sm_data_t [NL-1:0] sm3_read_data;
  logic [PBL-1:0]    sm3_piggyback_data;
  logic              sm3_error;

  scratchpad_memory_result_collector #(
    .NUM_LANES(NL),
    .PB_LEN   (PBL)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .sm2_valid          (sm2_valid),
    .sm2_is_store       (sm2_is_store),
    .sm2_satisfied_mask (sm2_satisfied_mask),
    .sm2_read_data      (sm2_read_data),
    .sm2_is_last_request(sm2_is_last_request),
    .sm2_piggyback_data (sm2_piggyback_data),
    .sm3_valid          (sm3_valid),
    .sm3_is_store       (sm3_is_store),
    .sm3_read_data      (sm3_read_data),
    .sm3_piggyback_data (sm3_piggyback_data),
    .sm3_error          (sm3_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight instruction and last expected outputs
  bit          busy;
  logic [31:0] m_lane [NL];
  logic [NL-1:0] m_mask;
  bit          m_store;
  logic [PBL-1:0] m_pb;
  bit          m_ovl;
  bit          e_valid;
  bit          e_store;
  sm_data_t [NL-1:0] e_data;
  logic [PBL-1:0] e_pb;
  bit          e_err;

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ".valid"}, VW'(sm3_valid), VW'(e_valid));
    check_eq({ctx, ".store"}, VW'(sm3_is_store), VW'(e_store));
    check_eq({ctx, ".data"}, sm3_read_data, e_data);
    check_eq({ctx, ".pb"}, VW'(sm3_piggyback_data), VW'(e_pb));
    check_eq({ctx, ".err"}, VW'(sm3_error), VW'(e_err));
  endtask

  task automatic model_reset();
    busy    = 1'b0;
    m_mask  = '0;
    m_ovl   = 1'b0;
    e_valid = 1'b0;
    e_store = 1'b0;
    e_data  = '0;
    e_pb    = '0;
    e_err   = 1'b0;
  endtask

  task automatic model_cycle(input bit v, input bit st, input bit last,
                             input logic [NL-1:0] mask, input logic [PBL-1:0] pb,
                             input sm_data_t [NL-1:0] rd);
    e_valid = 1'b0;
    if (v) begin
      if (!busy) begin
        busy = 1'b1;
        for (int i = 0; i < NL; i++) m_lane[i] = '0;
        m_mask  = '0;
        m_store = st;
        m_pb    = pb;
        m_ovl   = 1'b0;
      end
      if ((mask & m_mask) != 0) m_ovl = 1'b1;
      for (int i = 0; i < NL; i++) if (mask[i]) m_lane[i] = rd[i];
      m_mask = m_mask | mask;
      if (last) begin
        e_valid = 1'b1;
        e_store = m_store;
        for (int i = 0; i < NL; i++) e_data[i] = m_store ? 32'd0 : m_lane[i];
        e_pb  = m_pb;
        e_err = ERR_EN && m_ovl;
        busy  = 1'b0;
      end
    end
  endtask

  task automatic beat(input string ctx, input bit v, input bit st, input bit last,
                      input logic [NL-1:0] mask, input logic [PBL-1:0] pb,
                      input sm_data_t [NL-1:0] rd);
    sm2_valid           = v;
    sm2_is_store        = st;
    sm2_is_last_request = last;
    sm2_satisfied_mask  = mask;
    sm2_piggyback_data  = pb;
    sm2_read_data       = rd;
    @(posedge clock);
    #1;
    model_cycle(v, st, last, mask, pb, rd);
    check_outputs(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    sm_data_t [NL-1:0] junk;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NL; i++) junk[i] = $urandom;
      beat(ctx, 1'b0, 1'($urandom), 1'($urandom), NL'($urandom), PBL'($urandom), junk);
    end
  endtask

  task automatic do_reset(input string ctx);
    sm2_valid = 1'b0;
    reset     = 1'b1;
    #1;
    model_reset();
    check_outputs(ctx);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic sm_data_t [NL-1:0] rand_data();
    sm_data_t [NL-1:0] r;
    for (int i = 0; i < NL; i++) r[i] = $urandom;
    return r;
  endfunction

  initial begin
    sm_data_t [NL-1:0] rd;
    sm2_valid           = 1'b0;
    sm2_is_store        = 1'b0;
    sm2_satisfied_mask  = '0;
    sm2_read_data       = '0;
    sm2_is_last_request = 1'b0;
    sm2_piggyback_data  = '0;
    reset               = 1'b1;
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle("post_reset", 2);

    // Single full-width load beat
    for (int i = 0; i < NL; i++) rd[i] = i;
    beat("single", 1, 0, 1, 16'hFFFF, 8'h05, rd);
    idle("single_drop", 2);

    // Three beats with idle gaps
    beat("multi1", 1, 0, 0, 16'h000F, 8'h21, rand_data());
    idle("multi_gap1", 3);
    beat("multi2", 1, 0, 0, 16'h00F0, 8'h22, rand_data());
    idle("multi_gap2", 2);
    beat("multi3", 1, 0, 1, 16'hFF00, 8'h23, rand_data());
    idle("multi_after", 1);

    // Store zeroes all lanes
    beat("store", 1, 1, 1, 16'hFFFF, 8'h3C, rand_data());
    idle("store_after", 1);

    // Back-to-back instructions
    beat("b2b_a", 1, 0, 1, 16'h0F0F, 8'h41, rand_data());
    beat("b2b_b1", 1, 1, 0, 16'h00FF, 8'h42, rand_data());
    beat("b2b_b2", 1, 0, 1, 16'hFF00, 8'h99, rand_data());
    beat("b2b_c", 1, 0, 1, 16'h1234, 8'h43, rand_data());
    idle("b2b_after", 1);

    // Overlapping lanes: later data wins, error only with the check enabled
    beat("ovl1", 1, 0, 0, 16'h0003, 8'h51, rand_data());
    beat("ovl2", 1, 0, 1, 16'h0002, 8'h52, rand_data());
    beat("ovl_clear", 1, 0, 1, 16'h0001, 8'h53, rand_data());
    idle("ovl_after", 1);

    // Reset mid-instruction discards the partial result
    beat("mid1", 1, 0, 0, 16'h00FF, 8'h61, rand_data());
    do_reset("mid_reset");
    idle("mid_idle", 3);
    beat("mid_next1", 1, 0, 0, 16'hF000, 8'h62, rand_data());
    beat("mid_next2", 1, 0, 1, 16'h0F00, 8'h63, rand_data());
    idle("mid_after", 1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_reset");
      end else begin
        beat("rnd", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 3) == 0),
             $urandom_range(0, 2) == 0, NL'($urandom), PBL'($urandom), rand_data());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
